// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by a 2**ADDR_W x 32-bit register-file memory at BASE_ADDR.
// Independent write (AW/W/B) and read (AR/R) FSMs; FIXED/INCR/WRAP(as INCR) bursts.
// Ports:
//   clk, rst                 clock, async active-high reset
//   WR_ADDR_* / WR_DATA_*    AW and W channels (id, addr, len, burst / data, strb, last)
//   WR_BACK_*                B channel (id, resp, valid, ready)
//   RD_ADDR_*                AR channel (id, addr, len, burst)
//   RD_BACK_ID, RD_DATA_*    R channel (id, data, resp, last, valid, ready)
module axi_ram_slave #(
  parameter int          S_ID      = 4,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [S_ID-1:0] WR_ADDR_ID,
  input  logic [31:0]     WR_ADDR,
  input  logic [7:0]      WR_ADDR_LEN,
  input  logic [1:0]      WR_ADDR_BURST,
  input  logic            WR_ADDR_VALID,
  output logic            WR_ADDR_READY,
  input  logic [31:0]     WR_DATA,
  input  logic [3:0]      WR_STRB,
  input  logic            WR_DATA_LAST,
  input  logic            WR_DATA_VALID,
  output logic            WR_DATA_READY,
  output logic [S_ID-1:0] WR_BACK_ID,
  output logic [1:0]      WR_BACK_RESP,
  output logic            WR_BACK_VALID,
  input  logic            WR_BACK_READY,
  input  logic [S_ID-1:0] RD_ADDR_ID,
  input  logic [31:0]     RD_ADDR,
  input  logic [7:0]      RD_ADDR_LEN,
  input  logic [1:0]      RD_ADDR_BURST,
  input  logic            RD_ADDR_VALID,
  output logic            RD_ADDR_READY,
  output logic [S_ID-1:0] RD_BACK_ID,
  output logic [31:0]     RD_DATA,
  output logic [1:0]      RD_DATA_RESP,
  output logic            RD_DATA_LAST,
  output logic            RD_DATA_VALID,
  input  logic            RD_DATA_READY
);

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [31:0] r_mem [0:2**ADDR_W-1];

  function automatic logic [1:0] f_decode(
    input logic [31:0] addr,
    input logic [1:0]  burst
  );
    if (addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2])
      return RESP_DECERR;
    else if (burst == 2'd3)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

  // ---------------- write channel ----------------
  w_state_t          r_wstate, w_wstate_nxt;
  logic [S_ID-1:0]   r_wid;
  logic [ADDR_W-1:0] r_widx;
  logic [7:0]        r_wlen, r_wcnt;
  logic              r_wfixed, r_wok;
  logic [1:0]        r_wresp;
  logic [1:0]        w_aw_err;
  logic              w_aw_hs, w_w_hs, w_wfinal;

  assign w_aw_err  = f_decode(WR_ADDR, WR_ADDR_BURST);
  assign w_aw_hs   = WR_ADDR_VALID & WR_ADDR_READY;
  assign w_w_hs    = WR_DATA_VALID & WR_DATA_READY;
  assign w_wfinal  = (r_wcnt == r_wlen);
  assign WR_BACK_ID   = r_wid;
  assign WR_BACK_RESP = r_wresp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt  = r_wstate;
    WR_ADDR_READY = 1'b0;
    WR_DATA_READY = 1'b0;
    WR_BACK_VALID = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        // gated so every output reads 0 while reset is held
        WR_ADDR_READY = ~rst;
        if (WR_ADDR_VALID && !rst) w_wstate_nxt = W_DATA;
      end
      W_DATA: begin
        WR_DATA_READY = 1'b1;
        if (WR_DATA_VALID && w_wfinal) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        WR_BACK_VALID = 1'b1;
        if (WR_BACK_READY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= '0;
      r_wcnt   <= '0;
      r_wfixed <= 1'b0;
      r_wok    <= 1'b0;
      r_wresp  <= RESP_OKAY;
    end else begin
      if (w_aw_hs) begin
        r_wid    <= WR_ADDR_ID;
        r_widx   <= WR_ADDR[ADDR_W+1:2];
        r_wlen   <= WR_ADDR_LEN;
        r_wcnt   <= '0;
        r_wfixed <= (WR_ADDR_BURST == 2'd0);
        r_wok    <= (w_aw_err == RESP_OKAY);
        r_wresp  <= w_aw_err;
      end
      if (w_w_hs) begin
        r_wcnt <= r_wcnt + 8'd1;
        if (!r_wfixed) r_widx <= r_widx + 1'b1;
        // LAST is only checked; a decode error keeps priority
        if ((WR_DATA_LAST != w_wfinal) && (r_wresp == RESP_OKAY))
          r_wresp <= RESP_SLVERR;
      end
    end
  end

  // memory contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_w_hs && r_wok) begin
      for (int b = 0; b < 4; b++)
        if (WR_STRB[b]) r_mem[r_widx][8*b +: 8] <= WR_DATA[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  r_state_t          r_rstate, w_rstate_nxt;
  logic [S_ID-1:0]   r_rid;
  logic [ADDR_W-1:0] r_ridx;
  logic [7:0]        r_rlen, r_rcnt;
  logic              r_rfixed, r_rok, r_rlast;
  logic [1:0]        r_rresp;
  logic [31:0]       r_rdata;
  logic [1:0]        w_ar_err;
  logic [ADDR_W-1:0] w_ar_idx;
  logic              w_ar_hs, w_r_hs;
  logic              w_unused;

  assign w_ar_err = f_decode(RD_ADDR, RD_ADDR_BURST);
  assign w_ar_idx = RD_ADDR[ADDR_W+1:2];
  assign w_ar_hs  = RD_ADDR_VALID & RD_ADDR_READY;
  assign w_r_hs   = RD_DATA_VALID & RD_DATA_READY;
  assign w_unused = ^{WR_ADDR[1:0], RD_ADDR[1:0]};
  assign RD_BACK_ID   = r_rid;
  assign RD_DATA      = r_rdata;
  assign RD_DATA_RESP = r_rresp;
  assign RD_DATA_LAST = r_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt  = r_rstate;
    RD_ADDR_READY = 1'b0;
    RD_DATA_VALID = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        RD_ADDR_READY = ~rst;
        if (RD_ADDR_VALID && !rst) w_rstate_nxt = R_DATA;
      end
      R_DATA: begin
        RD_DATA_VALID = 1'b1;
        if (RD_DATA_READY && r_rlast) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // r_ridx always points at the beat to be loaded next, so a handshake
  // can refill the output register on the same edge (no bubbles)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rfixed <= 1'b0;
      r_rok    <= 1'b0;
      r_rlast  <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rid    <= RD_ADDR_ID;
      r_rlen   <= RD_ADDR_LEN;
      r_rcnt   <= '0;
      r_rfixed <= (RD_ADDR_BURST == 2'd0);
      r_rok    <= (w_ar_err == RESP_OKAY);
      r_rresp  <= w_ar_err;
      r_rlast  <= (RD_ADDR_LEN == 8'd0);
      r_rdata  <= (w_ar_err == RESP_OKAY) ? r_mem[w_ar_idx] : 32'd0;
      r_ridx   <= (RD_ADDR_BURST == 2'd0) ? w_ar_idx : w_ar_idx + 1'b1;
    end else if (w_r_hs && !r_rlast) begin
      r_rcnt  <= r_rcnt + 8'd1;
      r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
      r_rdata <= r_rok ? r_mem[r_ridx] : 32'd0;
      if (!r_rfixed) r_ridx <= r_ridx + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave.
// Hand-computed expectations; every comparison goes through check().
module tb_axi_ram_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  WR_ADDR_ID = '0;
  logic [31:0] WR_ADDR = '0;
  logic [7:0]  WR_ADDR_LEN = '0;
  logic [1:0]  WR_ADDR_BURST = '0;
  logic        WR_ADDR_VALID = 1'b0;
  logic        WR_ADDR_READY;
  logic [31:0] WR_DATA = '0;
  logic [3:0]  WR_STRB = '0;
  logic        WR_DATA_LAST = 1'b0;
  logic        WR_DATA_VALID = 1'b0;
  logic        WR_DATA_READY;
  logic [3:0]  WR_BACK_ID;
  logic [1:0]  WR_BACK_RESP;
  logic        WR_BACK_VALID;
  logic        WR_BACK_READY = 1'b0;
  logic [3:0]  RD_ADDR_ID = '0;
  logic [31:0] RD_ADDR = '0;
  logic [7:0]  RD_ADDR_LEN = '0;
  logic [1:0]  RD_ADDR_BURST = '0;
  logic        RD_ADDR_VALID = 1'b0;
  logic        RD_ADDR_READY;
  logic [3:0]  RD_BACK_ID;
  logic [31:0] RD_DATA;
  logic [1:0]  RD_DATA_RESP;
  logic        RD_DATA_LAST;
  logic        RD_DATA_VALID;
  logic        RD_DATA_READY = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_ram_slave #(.S_ID(4), .ADDR_W(10), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .WR_ADDR_ID(WR_ADDR_ID), .WR_ADDR(WR_ADDR),
    .WR_ADDR_LEN(WR_ADDR_LEN), .WR_ADDR_BURST(WR_ADDR_BURST),
    .WR_ADDR_VALID(WR_ADDR_VALID), .WR_ADDR_READY(WR_ADDR_READY),
    .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_DATA_LAST(WR_DATA_LAST),
    .WR_DATA_VALID(WR_DATA_VALID), .WR_DATA_READY(WR_DATA_READY),
    .WR_BACK_ID(WR_BACK_ID), .WR_BACK_RESP(WR_BACK_RESP),
    .WR_BACK_VALID(WR_BACK_VALID), .WR_BACK_READY(WR_BACK_READY),
    .RD_ADDR_ID(RD_ADDR_ID), .RD_ADDR(RD_ADDR),
    .RD_ADDR_LEN(RD_ADDR_LEN), .RD_ADDR_BURST(RD_ADDR_BURST),
    .RD_ADDR_VALID(RD_ADDR_VALID), .RD_ADDR_READY(RD_ADDR_READY),
    .RD_BACK_ID(RD_BACK_ID), .RD_DATA(RD_DATA),
    .RD_DATA_RESP(RD_DATA_RESP), .RD_DATA_LAST(RD_DATA_LAST),
    .RD_DATA_VALID(RD_DATA_VALID), .RD_DATA_READY(RD_DATA_READY)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({WR_ADDR_READY, WR_DATA_READY, WR_BACK_VALID,
                              RD_ADDR_READY, RD_DATA_VALID, RD_DATA_LAST,
                              WR_BACK_ID, WR_BACK_RESP, RD_BACK_ID,
                              RD_DATA_RESP}), 32'd0);
    check({tag, "_rdata"}, RD_DATA, 32'd0);
  endtask

  // bad: beat index whose LAST is inverted (-1 for none)
  task automatic wr(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [31:0] d0, input logic [31:0] step,
                    input logic [3:0] strb, input int bad,
                    input int bdly, input logic [1:0] eresp);
    int t;
    @(negedge clk);
    WR_ADDR_ID = id; WR_ADDR = addr; WR_ADDR_LEN = len;
    WR_ADDR_BURST = burst; WR_ADDR_VALID = 1'b1;
    t = 0;
    while (!WR_ADDR_READY && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      check("aw_timeout", 32'd0, 32'd1);
      WR_ADDR_VALID = 1'b0;
      return;
    end
    @(negedge clk);
    WR_ADDR_VALID = 1'b0;
    check("aw2w", 32'(WR_DATA_READY), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      WR_DATA = d0 + 32'(i) * step;
      WR_STRB = strb;
      WR_DATA_LAST = (i == int'(len)) ^ (i == bad);
      WR_DATA_VALID = 1'b1;
      t = 0;
      while (!WR_DATA_READY && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        check("w_timeout", 32'd0, 32'd1);
        WR_DATA_VALID = 1'b0;
        return;
      end
      @(negedge clk);
    end
    WR_DATA_VALID = 1'b0;
    WR_DATA_LAST = 1'b0;
    check("w2b", 32'(WR_BACK_VALID), 32'd1);
    for (int k = 0; k < bdly; k++) begin
      check("b_hold_v", 32'(WR_BACK_VALID), 32'd1);
      check("b_hold_id", 32'(WR_BACK_ID), 32'(id));
      check("b_hold_resp", 32'(WR_BACK_RESP), 32'(eresp));
      @(negedge clk);
    end
    check("bid", 32'(WR_BACK_ID), 32'(id));
    check("bresp", 32'(WR_BACK_RESP), 32'(eresp));
    WR_BACK_READY = 1'b1;
    @(negedge clk);
    WR_BACK_READY = 1'b0;
    check("b_done", 32'(WR_BACK_VALID), 32'd0);
    check("aw_again", 32'(WR_ADDR_READY), 32'd1);
  endtask

  // expected beat n data = d0 + n*step
  task automatic rd(input logic [3:0] id, input logic [31:0] addr,
                    input logic [7:0] len, input logic [1:0] burst,
                    input logic [31:0] d0, input logic [31:0] step,
                    input logic [1:0] eresp, input bit toggle);
    int t, beat, cyc;
    @(negedge clk);
    RD_ADDR_ID = id; RD_ADDR = addr; RD_ADDR_LEN = len;
    RD_ADDR_BURST = burst; RD_ADDR_VALID = 1'b1;
    t = 0;
    while (!RD_ADDR_READY && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      check("ar_timeout", 32'd0, 32'd1);
      RD_ADDR_VALID = 1'b0;
      return;
    end
    @(negedge clk);
    RD_ADDR_VALID = 1'b0;
    check("ar2r", 32'(RD_DATA_VALID), 32'd1);
    beat = 0;
    cyc = 0;
    while (beat <= int'(len) && cyc < 600) begin
      RD_DATA_READY = toggle ? (cyc % 2 == 0) : 1'b1;
      if (!toggle) check("r_nobubble", 32'(RD_DATA_VALID), 32'd1);
      if (RD_DATA_VALID) begin
        check("rdata", RD_DATA, d0 + 32'(beat) * step);
        check("rlast", 32'(RD_DATA_LAST), 32'(beat == int'(len)));
        check("rresp", 32'(RD_DATA_RESP), 32'(eresp));
        check("rid", 32'(RD_BACK_ID), 32'(id));
        if (RD_DATA_READY) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    RD_DATA_READY = 1'b0;
    if (beat <= int'(len)) check("r_timeout", 32'(beat), 32'(len) + 1);
    check("r_done", 32'(RD_DATA_VALID), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // single beat
    wr(4'd3, 32'h10, 8'd0, 2'd1, 32'hDEADBEEF, 0, 4'hF, -1, 0, 2'd0);
    rd(4'd3, 32'h10, 8'd0, 2'd1, 32'hDEADBEEF, 0, 2'd0, 1'b0);

    // INCR len=3, back-to-back read beats
    wr(4'd1, 32'h20, 8'd3, 2'd1, 32'd1, 32'd1, 4'hF, -1, 0, 2'd0);
    rd(4'd2, 32'h20, 8'd3, 2'd1, 32'd1, 32'd1, 2'd0, 1'b0);

    // byte strobes
    wr(4'd4, 32'h40, 8'd0, 2'd1, 32'hFFFFFFFF, 0, 4'hF, -1, 0, 2'd0);
    wr(4'd4, 32'h40, 8'd0, 2'd1, 32'h00000000, 0, 4'b0101, -1, 0, 2'd0);
    rd(4'd4, 32'h40, 8'd0, 2'd1, 32'hFF00FF00, 0, 2'd0, 1'b0);

    // out of range: DECERR, aliased word 0 untouched
    wr(4'd5, 32'h0, 8'd0, 2'd1, 32'h12345678, 0, 4'hF, -1, 0, 2'd0);
    wr(4'd6, 32'h1000, 8'd1, 2'd1, 32'hAAAA0000, 32'd1, 4'hF, -1, 0, 2'd3);
    rd(4'd5, 32'h0, 8'd0, 2'd1, 32'h12345678, 0, 2'd0, 1'b0);
    rd(4'd6, 32'h1000, 8'd1, 2'd1, 32'd0, 0, 2'd3, 1'b0);

    // backpressure on B and R
    wr(4'd7, 32'h100, 8'd7, 2'd1, 32'h100, 32'd1, 4'hF, -1, 5, 2'd0);
    rd(4'd7, 32'h100, 8'd7, 2'd1, 32'h100, 32'd1, 2'd0, 1'b1);

    // FIXED burst: last beat wins at one index
    wr(4'd8, 32'h80, 8'd2, 2'd0, 32'd5, 32'd1, 4'hF, -1, 0, 2'd0);
    rd(4'd8, 32'h80, 8'd2, 2'd0, 32'd7, 0, 2'd0, 1'b0);

    // WRAP read behaves as INCR
    rd(4'd8, 32'h20, 8'd3, 2'd2, 32'd1, 32'd1, 2'd0, 1'b0);

    // LAST mismatch: SLVERR but data written
    wr(4'd9, 32'h200, 8'd1, 2'd1, 32'h77, 32'd1, 4'hF, 0, 0, 2'd2);
    rd(4'd9, 32'h200, 8'd1, 2'd1, 32'h77, 32'd1, 2'd0, 1'b0);

    // reserved burst: SLVERR, no write, read data 0
    wr(4'd10, 32'h10, 8'd0, 2'd3, 32'h55, 0, 4'hF, -1, 0, 2'd2);
    rd(4'd10, 32'h10, 8'd0, 2'd1, 32'hDEADBEEF, 0, 2'd0, 1'b0);
    rd(4'd10, 32'h10, 8'd0, 2'd3, 32'd0, 0, 2'd2, 1'b0);

    // index wraps at memory top
    wr(4'd11, 32'hFFC, 8'd1, 2'd1, 32'hA0, 32'd1, 4'hF, -1, 0, 2'd0);
    rd(4'd11, 32'hFFC, 8'd1, 2'd1, 32'hA0, 32'd1, 2'd0, 1'b0);
    rd(4'd11, 32'h0, 8'd0, 2'd1, 32'hA1, 0, 2'd0, 1'b0);

    // reset during beat 2 of concurrent len=7 write and read
    @(negedge clk);
    WR_ADDR_ID = 4'd5; WR_ADDR = 32'h400; WR_ADDR_LEN = 8'd7;
    WR_ADDR_BURST = 2'd1; WR_ADDR_VALID = 1'b1;
    RD_ADDR_ID = 4'd6; RD_ADDR = 32'h100; RD_ADDR_LEN = 8'd7;
    RD_ADDR_BURST = 2'd1; RD_ADDR_VALID = 1'b1;
    @(negedge clk);
    WR_ADDR_VALID = 1'b0; RD_ADDR_VALID = 1'b0;
    WR_DATA = 32'h11; WR_STRB = 4'hF; WR_DATA_VALID = 1'b1;
    RD_DATA_READY = 1'b1;
    @(negedge clk);
    check("rst_pre_w", 32'(WR_DATA_READY), 32'd1);
    check("rst_pre_r", RD_DATA, 32'h101);
    WR_DATA = 32'h12;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    WR_DATA_VALID = 1'b0; RD_DATA_READY = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_aw_rdy", 32'(WR_ADDR_READY), 32'd1);
    check("post_ar_rdy", 32'(RD_ADDR_READY), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("post_no_b", 32'(WR_BACK_VALID), 32'd0);
      check("post_no_r", 32'(RD_DATA_VALID), 32'd0);
    end
    wr(4'd12, 32'h400, 8'd1, 2'd1, 32'h31, 32'd1, 4'hF, -1, 0, 2'd0);
    rd(4'd12, 32'h400, 8'd1, 2'd1, 32'h31, 32'd1, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
